frame_capture_ctrl: RTL
=======================

# frame_capture_ctrl

Parametrised camera frame-capture controller sitting between the camera pixel-write path and the frame buffer. On a software start it arms on the next frame-boundary edge of vsync, gates the camera write-enable for a programmable number of frames (with optional frame skipping between captured frames), and generates the buffer write address. It reports done until acknowledged, and supports abort and address-overflow protection.

## Interface
Parameters:
- ADDR_W, 17, width of frame-buffer write address.
- NFR_W, 4, width of frame-count field.
- SKIP_W, 3, width of skip-count field.
- VSYNC_ACT_HIGH, 1, 1: frame boundary is rising vsync edge; 0: falling edge.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin capture; sampled only in IDLE.
- num_frames  in  NFR_W  frames to capture; latched on accepted start; 0 treated as 1.
- skip  in  SKIP_W  frames discarded after each captured frame except the last; latched on accepted start.
- abort  in  1  return to IDLE from any state, highest priority.
- ack  in  1  clears done.
- vsync  in  1  camera vertical sync, already synchronous to clk.
- wen  in  1  camera pixel write strobe.
- wen_out  out  1  gated write enable to frame buffer.
- wr_addr  out  ADDR_W  buffer address for the current pixel.
- frame_idx  out  NFR_W  captured frames completed.
- busy  out  1  high in ARM, CAPTURE, SKIP.
- done  out  1  high in DONE.
- overflow  out  1  sticky: a write was dropped because the address was full.

## Operation
- vsync_q: vsync registered once; reset value is the inactive level (!VSYNC_ACT_HIGH).
- edge = (vsync == VSYNC_ACT_HIGH) && (vsync_q != VSYNC_ACT_HIGH); combinational; asserted in the first clk cycle vsync is sampled active.
- States: IDLE, ARM, CAPTURE, SKIP, DONE.
  - IDLE: on start, latch nf = max(num_frames, 1) and sk = skip; clear wr_addr, frame_idx, overflow; go to ARM.
  - ARM: on edge, go to CAPTURE.
  - CAPTURE: on edge, frame_idx += 1.
    - If the new frame_idx == nf, go to DONE.
    - Else if sk != 0, load skip_cnt = sk and go to SKIP.
    - Else stay in CAPTURE.
  - SKIP: on edge, skip_cnt -= 1; when it reaches 0, go to CAPTURE.
  - DONE: on ack, go to IDLE. start is ignored in DONE, including when it coincides with ack.
- abort (any state): go to IDLE next cycle. done stays low. wr_addr, frame_idx and overflow hold their values.
- start outside IDLE is ignored. Latched nf and sk do not change mid-capture.
- wen_out = wen && state == CAPTURE && !full. Combinational; includes the edge cycle that ends a frame.
- full = (wr_addr == 2^ADDR_W − 1) && addr_written.
  - Each wen_out pulse increments wr_addr, saturating at the top address.
  - addr_written marks that the top address has been written.
  - wen while in CAPTURE and full: no write; overflow set to 1 (sticky until the next accepted start or reset).
- wr_addr is continuous across captured frames; skipped frames do not advance it.

## Timing
- Reset values: state IDLE; wr_addr 0; frame_idx 0; wen_out 0 (state-gated); busy 0; done 0; overflow 0.
- Start to ARM: 1 cycle (busy high the cycle after start).
- ARM to CAPTURE: transition at the clock edge ending the edge cycle; the first gated wen is the one in the following cycle.
- Final edge in CAPTURE: wen in that cycle is still passed. done rises the next cycle and holds until ack is sampled. done falls and busy stays 0 the cycle after ack.
- wr_addr updates one cycle after each wen_out pulse and is stable during the pulse.
- abort and edge in the same cycle: abort wins, no counter update.
- Reset asserted mid-operation: all outputs take reset values immediately, asynchronously.

## Test plan
- Single frame: num_frames=1, skip=0; start, then vsync pulses at T1 and T2 with wen pulsed 100× between them. Required: 100 wen_out pulses; wr_addr=100; frame_idx=1; done high from T2+1 until ack.
- Multi-frame with skip: num_frames=3, skip=1, 10 wen per frame over 7 frame periods. Required: frames 1, 3 and 5 passed; wr_addr=30; done after the 6th edge; frame_idx=3.
- Overflow: ADDR_W=4, 20 wen in one frame. Required: exactly 16 wen_out pulses; wr_addr=15; overflow=1; done still asserted at frame end.
- Abort: assert abort mid-CAPTURE after 5 writes. Required: IDLE next cycle; wen_out 0; done never high; wr_addr=5.
- Polarity: VSYNC_ACT_HIGH=0, vsync idles high. Required: capture arms on the falling edge only; rising edges ignored.
- Handshake corner cases: num_frames=0 behaves as 1; start pulsed while busy is ignored; start and ack together in DONE give IDLE with no new capture.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// ---------------------------------------------------------------------------
// frame_capture_ctrl
//
// Camera frame-capture controller. It sits between the camera pixel-write
// path and the frame buffer. A software start arms the block. The next
// frame-boundary vsync edge opens capture. The camera write strobe is then
// gated through for a programmable number of frames. Optional skipped frames
// can sit between captured frames. The block also generates a linear buffer
// write address that saturates at the top of the buffer.
//
// Parameters
//   ADDR_W          width of the frame-buffer write address
//   NFR_W           width of the frame-count field
//   SKIP_W          width of the skip-count field
//   VSYNC_ACT_HIGH  1: frame boundary on rising vsync, 0: on falling vsync
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   start      in   begin a capture (only honoured in IDLE)
//   num_frames in   frames to capture, 0 behaves as 1
//   skip       in   frames discarded after each captured frame but the last
//   abort      in   return to IDLE from any state, highest priority
//   ack        in   acknowledge and clear done
//   vsync      in   camera vertical sync, already synchronous to clk
//   wen        in   camera pixel write strobe
//   wen_out    out  gated write enable to the frame buffer
//   wr_addr    out  buffer address for the current pixel
//   frame_idx  out  number of captured frames completed
//   busy       out  high while armed, capturing or skipping
//   done       out  high from capture completion until ack
//   overflow   out  sticky: a write was dropped because the buffer was full
// ---------------------------------------------------------------------------
module frame_capture_ctrl #(
  parameter int ADDR_W         = 17,
  parameter int NFR_W          = 4,
  parameter int SKIP_W         = 3,
  parameter bit VSYNC_ACT_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NFR_W-1:0]  num_frames,
  input  logic [SKIP_W-1:0] skip,
  input  logic              abort,
  input  logic              ack,
  input  logic              vsync,
  input  logic              wen,
  output logic              wen_out,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [NFR_W-1:0]  frame_idx,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_SKIP,
    S_DONE
  } state_e;

  localparam logic              VS_ACT   = VSYNC_ACT_HIGH;
  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

  state_e              state_q;
  logic                vsync_q;
  logic [NFR_W-1:0]    nf_q;
  logic [SKIP_W-1:0]   sk_q;
  logic [SKIP_W-1:0]   skip_cnt_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [NFR_W-1:0]    frame_idx_q;
  logic                addr_written_q;
  logic                overflow_q;
  logic                busy_q;
  logic                done_q;

  logic                frame_edge;
  logic                full;
  logic                capturing;
  logic [NFR_W-1:0]    frame_idx_inc;

  // NOTE: every signal assigned in always_comb gets a value on every path.
  // Otherwise synthesis infers a latch for the paths that leave it unset.
  always_comb begin
    frame_edge    = (vsync == VS_ACT) && (vsync_q != VS_ACT);
    // The top address is a real location. "full" means it has already been
    // written, not just reached, so the buffer holds exactly 2^ADDR_W pixels.
    full          = (wr_addr_q == ADDR_TOP) && addr_written_q;
    capturing     = (state_q == S_CAPTURE);
    wen_out       = wen && capturing && !full;
    frame_idx_inc = frame_idx_q + 1'b1;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  // Every register then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      vsync_q        <= ~VS_ACT;
      nf_q           <= '0;
      sk_q           <= '0;
      skip_cnt_q     <= '0;
      wr_addr_q      <= '0;
      frame_idx_q    <= '0;
      addr_written_q <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      vsync_q <= vsync;

      // Address advances on every passed write, including one in the cycle
      // that aborts or ends the frame, so it always matches what was written.
      if (wen_out) begin
        if (wr_addr_q != ADDR_TOP) wr_addr_q <= wr_addr_q + 1'b1;
        else                       addr_written_q <= 1'b1;
      end
      if (wen && capturing && full) overflow_q <= 1'b1;

      if (abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              nf_q           <= (num_frames == '0) ? NFR_W'(1) : num_frames;
              sk_q           <= skip;
              wr_addr_q      <= '0;
              addr_written_q <= 1'b0;
              frame_idx_q    <= '0;
              overflow_q     <= 1'b0;
              state_q        <= S_ARM;
              busy_q         <= 1'b1;
            end
          end
          S_ARM: begin
            if (frame_edge) state_q <= S_CAPTURE;
          end
          S_CAPTURE: begin
            if (frame_edge) begin
              frame_idx_q <= frame_idx_inc;
              if (frame_idx_inc == nf_q) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if (sk_q != '0) begin
                skip_cnt_q <= sk_q;
                state_q    <= S_SKIP;
              end
            end
          end
          S_SKIP: begin
            if (frame_edge) begin
              skip_cnt_q <= skip_cnt_q - 1'b1;
              if (skip_cnt_q == SKIP_W'(1)) state_q <= S_CAPTURE;
            end
          end
          S_DONE: begin
            // start is deliberately ignored here, even alongside ack.
            if (ack) begin
              state_q <= S_IDLE;
              done_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_addr   = wr_addr_q;
  assign frame_idx = frame_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule
